// File: rtl/spi_cfg_regfile_if.sv
// SPI pin bundle between an external SPI master and the config register file.
// The master drives sck/nss/mosi; the register file drives miso and its output enable.
interface spi_cfg_regfile_if;
   logic sck;
   logic nss;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (output sck, output nss, output mosi, input miso, input miso_oe);
   modport slave  (input sck, input nss, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_cfg_regfile.sv
// Addressed SPI mode-0 slave config register file, oversampled on the system clock.
// Writes land in shadow storage and are committed to the live config when nss rises.
module spi_cfg_regfile #(
   parameter int NREGS  = 8,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                    clk,
   input  logic                    arstn,
   spi_cfg_regfile_if.slave        spi,
   output logic [NREGS*DATA_W-1:0] cfg,
   output logic                    mute,
   output logic                    trig
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [ADDR_W:0] NREGS_L  = NREGS[ADDR_W:0];
   localparam logic [4:0]      LAST_CMD = 5'd7;
   localparam logic [4:0]      LAST_DAT = 5'(DATA_W - 1);

   // Pin synchronisers; the third sck/nss stage provides edge detection.
   logic [2:0] sck_sq;
   logic [2:0] nss_sq;
   logic [1:0] mosi_sq;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         sck_sq  <= 3'b000;
         nss_sq  <= 3'b111;
         mosi_sq <= 2'b00;
      end else begin
         sck_sq  <= {sck_sq[1:0], spi.sck};
         nss_sq  <= {nss_sq[1:0], spi.nss};
         mosi_sq <= {mosi_sq[0], spi.mosi};
      end
   end

   logic sck_rise, sck_fall, nss_rise, nss_fall, mosi_s;
   assign sck_rise = sck_sq[1] & ~sck_sq[2];
   assign sck_fall = ~sck_sq[1] & sck_sq[2];
   assign nss_rise = nss_sq[1] & ~nss_sq[2];
   assign nss_fall = ~nss_sq[1] & nss_sq[2];
   assign mosi_s   = mosi_sq[1];

   logic [1:0]        state_q;
   logic [7:0]        cmd_q;
   logic [DATA_W-2:0] word_q;
   logic [4:0]        bit_cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              have_word_q;
   logic              reload_q;
   logic [DATA_W-1:0] out_q;
   logic              trig_q;
   logic [DATA_W-1:0] cfg_q    [NREGS];
   logic [DATA_W-1:0] shadow_q [NREGS];

   logic [7:0]        cmd_d;
   logic [DATA_W-1:0] word_d;
   logic              addr_ok;
   assign cmd_d   = {cmd_q[6:0], mosi_s};
   assign word_d  = {word_q, mosi_s};
   assign addr_ok = ({1'b0, addr_q} < NREGS_L);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         word_q      <= '0;
         bit_cnt_q   <= '0;
         addr_q      <= '0;
         have_word_q <= 1'b0;
         reload_q    <= 1'b0;
         out_q       <= '0;
         trig_q      <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            cfg_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         trig_q <= 1'b0;
         if (nss_rise) begin
            // Reaching DATA means the command byte was complete.
            state_q <= ST_IDLE;
            if (state_q == ST_DATA) begin
               if (cmd_q[7] && have_word_q) begin
                  for (int i = 0; i < NREGS; i++) cfg_q[i] <= shadow_q[i];
               end
               trig_q <= cmd_q[6];
            end
         end else if (nss_fall) begin
            state_q     <= ST_CMD;
            bit_cnt_q   <= '0;
            have_word_q <= 1'b0;
            reload_q    <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < NREGS; i++) shadow_q[i] <= cfg_q[i];
         end else begin
            case (state_q)
               ST_CMD: begin
                  if (sck_rise) begin
                     cmd_q <= cmd_d;
                     if (bit_cnt_q == LAST_CMD) begin
                        state_q   <= ST_DATA;
                        addr_q    <= cmd_d[ADDR_W-1:0];
                        bit_cnt_q <= '0;
                        reload_q  <= 1'b1;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               ST_DATA: begin
                  if (sck_rise) begin
                     word_q <= word_d[DATA_W-2:0];
                     if (bit_cnt_q == LAST_DAT) begin
                        if (cmd_q[7] && addr_ok) shadow_q[addr_q] <= word_d;
                        addr_q      <= addr_q + 1'b1;
                        have_word_q <= 1'b1;
                        bit_cnt_q   <= '0;
                        reload_q    <= 1'b1;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
                  // Read-back always sources committed cfg, never shadow.
                  if (sck_fall) begin
                     if (reload_q) begin
                        out_q    <= addr_ok ? cfg_q[addr_q] : '0;
                        reload_q <= 1'b0;
                     end else begin
                        out_q <= out_q << 1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_cfg
         assign cfg[gi*DATA_W +: DATA_W] = cfg_q[gi];
      end
   endgenerate

   assign spi.miso    = (state_q == ST_DATA) & out_q[DATA_W-1];
   assign spi.miso_oe = ~nss_sq[1];
   assign mute        = ~nss_sq[1];
   assign trig        = trig_q;
endmodule
